// File: rtl/fc_convert_scheduler.sv
// rtl/fc_convert_scheduler.sv - sequenced FP16 to FP32 vector converter, LANES elements per clock
// Captures a NODES-wide half vector on start and fills the single-precision result chunk by chunk.
module fc_convert_scheduler #(
   parameter int DATA_WIDTH_1 = 16,
   parameter int DATA_WIDTH_2 = 32,
   parameter int NODES        = 400,
   parameter int LANES        = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [DATA_WIDTH_1*NODES-1:0]  input_fc,
   input  logic                           ack,
   output logic [DATA_WIDTH_2*NODES-1:0]  output_fc,
   output logic                           busy,
   output logic                           done
);

   localparam int IW = $clog2(NODES + LANES + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]                    state_q, state_d;
   logic [DATA_WIDTH_1*NODES-1:0] buf_q, buf_d;
   logic [DATA_WIDTH_2*NODES-1:0] out_q, out_d;
   logic [IW-1:0]                 idx_q, idx_d;
   logic                          busy_q, busy_d;
   logic                          done_q, done_d;

   // Subnormal halves flush to signed zero; Inf/NaN keep the mantissa as payload.
   function automatic logic [31:0] half_to_single(input logic [15:0] h);
      logic        s;
      logic [4:0]  e;
      logic [9:0]  m;
      logic [31:0] r;
      s = h[15];
      e = h[14:10];
      m = h[9:0];
      if (e == 5'd0) begin
         r = {s, 31'd0};
      end else if (e == 5'd31) begin
         r = {s, 8'hFF, m, 13'd0};
      end else begin
         r = {s, {3'b000, e} + 8'd112, m, 13'd0};
      end
      return r;
   endfunction

   always_comb begin
      logic [IW-1:0] el;
      logic          last;
      state_d = state_q;
      buf_d   = buf_q;
      out_d   = out_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      done_d  = done_q;
      el      = '0;
      last    = (idx_q + IW'(LANES)) >= IW'(NODES);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               buf_d   = input_fc;
               idx_d   = '0;
               state_d = S_RUN;
               busy_d  = 1'b1;
            end
         end
         S_RUN: begin
            // Lanes past the end of the vector in a partial last chunk write nothing.
            for (int l = 0; l < LANES; l++) begin
               el = idx_q + IW'(l);
               if (el < IW'(NODES)) begin
                  out_d[el*DATA_WIDTH_2 +: DATA_WIDTH_2] =
                     half_to_single(buf_q[el*DATA_WIDTH_1 +: DATA_WIDTH_1]);
               end
            end
            if (last) begin
               idx_d   = '0;
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               idx_d = idx_q + IW'(LANES);
            end
         end
         S_DONE: begin
            if (ack) begin
               done_d = 1'b0;
               if (start) begin
                  buf_d   = input_fc;
                  idx_d   = '0;
                  state_d = S_RUN;
                  busy_d  = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         buf_q   <= '0;
         out_q   <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         out_q   <= out_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign output_fc = out_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_fc_convert_scheduler.sv
// tb/tb_fc_convert_scheduler.sv - directed table-driven bench for fc_convert_scheduler
// Drives on negedge, samples on negedge after the active edge has settled.
module tb_fc_convert_scheduler;

   localparam int N  = 400;
   localparam int SN = 5;

   typedef struct {
      logic [15:0] h;
      logic [31:0] f;
   } vec_t;

   logic              clk;
   logic              reset;
   logic              start;
   logic              ack;
   logic [16*N-1:0]   input_fc;
   logic [32*N-1:0]   output_fc;
   logic              busy;
   logic              done;

   logic              s_start;
   logic              s_ack;
   logic [16*SN-1:0]  s_input_fc;
   logic [32*SN-1:0]  s_output_fc;
   logic              s_busy;
   logic              s_done;

   logic [16*N-1:0]   in_vec;
   logic [32*N-1:0]   exp_vec;

   int n_cmp;
   int n_bad;
   int cyc;
   vec_t tbl[16];

   fc_convert_scheduler dut (
      .clk(clk), .reset(reset), .start(start), .input_fc(input_fc), .ack(ack),
      .output_fc(output_fc), .busy(busy), .done(done)
   );

   fc_convert_scheduler #(.NODES(SN), .LANES(2)) dut_small (
      .clk(clk), .reset(reset), .start(s_start), .input_fc(s_input_fc), .ack(s_ack),
      .output_fc(s_output_fc), .busy(s_busy), .done(s_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_vec(input string name);
      for (int i = 0; i < N; i++) begin
         chk32($sformatf("%s[%0d]", name, i), output_fc[i*32 +: 32], exp_vec[i*32 +: 32]);
      end
   endtask

   task automatic fill_uniform(input logic [15:0] h, input logic [31:0] f);
      for (int i = 0; i < N; i++) begin
         in_vec[i*16 +: 16]  = h;
         exp_vec[i*32 +: 32] = f;
      end
   endtask

   task automatic scramble_input();
      for (int i = 0; i < N / 2; i++) begin
         input_fc[i*32 +: 32] = $urandom;
      end
   endtask

   task automatic start_pulse();
      @(negedge clk);
      input_fc = in_vec;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   // Counts busy samples until done; optionally scrambles input_fc every cycle.
   task automatic wait_done(input bit scramble, output int busy_cycles);
      bit seen;
      seen        = 1'b0;
      busy_cycles = 0;
      for (int k = 0; k < 200 && !seen; k++) begin
         if (done) seen = 1'b1;
         else begin
            if (busy) busy_cycles++;
            if (scramble) scramble_input();
            @(negedge clk);
         end
      end
      chk32("done_timeout", {31'd0, seen}, 32'd1);
   endtask

   initial begin
      n_cmp      = 0;
      n_bad      = 0;
      reset      = 1'b0;
      start      = 1'b0;
      ack        = 1'b0;
      input_fc   = '0;
      s_start    = 1'b0;
      s_ack      = 1'b0;
      s_input_fc = '0;

      tbl[0]  = '{16'h3C00, 32'h3F800000};
      tbl[1]  = '{16'hC000, 32'hC0000000};
      tbl[2]  = '{16'h7C00, 32'h7F800000};
      tbl[3]  = '{16'h7E00, 32'h7FC00000};
      tbl[4]  = '{16'h0000, 32'h00000000};
      tbl[5]  = '{16'h8000, 32'h80000000};
      tbl[6]  = '{16'h0001, 32'h00000000};
      tbl[7]  = '{16'h7BFF, 32'h477FE000};
      tbl[8]  = '{16'h4000, 32'h40000000};
      tbl[9]  = '{16'h3800, 32'h3F000000};
      tbl[10] = '{16'h0400, 32'h38800000};
      tbl[11] = '{16'h83FF, 32'h80000000};
      tbl[12] = '{16'hFC00, 32'hFF800000};
      tbl[13] = '{16'h7C01, 32'h7F802000};
      tbl[14] = '{16'hFBFF, 32'hC77FE000};
      tbl[15] = '{16'h3555, 32'h3EAAA000};

      // Reset and idle
      repeat (2) @(negedge clk);
      chk32("rst_out_zero", {31'd0, output_fc == '0}, 32'd1);
      chk32("rst_busy", {31'd0, busy}, 32'd0);
      chk32("rst_done", {31'd0, done}, 32'd0);
      reset = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk32($sformatf("idle_%0d", k), {29'd0, busy, done, output_fc == '0}, 32'd1);
      end

      // Table vector, input scrambled throughout RUN
      fill_uniform(16'h3C00, 32'h3F800000);
      for (int i = 0; i < 16; i++) begin
         in_vec[i*16 +: 16]  = tbl[i].h;
         exp_vec[i*32 +: 32] = tbl[i].f;
      end
      start_pulse();
      wait_done(1'b1, cyc);
      chk32("busy_cycles", cyc, 32'd50);
      chk32("done_busy_low", {31'd0, busy}, 32'd0);
      check_vec("table");

      // DONE holds while ack=0, start and input ignored
      for (int k = 0; k < 20; k++) begin
         scramble_input();
         start = k[0];
         @(negedge clk);
         chk32($sformatf("hold_%0d", k), {29'd0, busy, done, output_fc == exp_vec}, 32'd3);
      end
      start = 1'b0;

      // ack and start together: straight back into RUN
      fill_uniform(16'hC000, 32'hC0000000);
      input_fc = in_vec;
      ack      = 1'b1;
      start    = 1'b1;
      @(negedge clk);
      ack      = 1'b0;
      start    = 1'b0;
      chk32("ackstart_busy", {31'd0, busy}, 32'd1);
      chk32("ackstart_done", {31'd0, done}, 32'd0);
      wait_done(1'b1, cyc);
      chk32("busy_cycles2", cyc, 32'd50);
      check_vec("neg2");

      // ack alone returns to IDLE with output held
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      @(negedge clk);
      chk32("ack_idle", {29'd0, busy, done, output_fc == exp_vec}, 32'd1);

      // Asynchronous reset mid-RUN after 20 chunks
      fill_uniform(16'h4000, 32'h40000000);
      start_pulse();
      repeat (20) @(negedge clk);
      chk32("mid_run_busy", {31'd0, busy}, 32'd1);
      #2 reset = 1'b0;
      #1;
      chk32("abort_out_zero", {31'd0, output_fc == '0}, 32'd1);
      chk32("abort_flags", {30'd0, busy, done}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk32("abort_idle", {30'd0, busy, done}, 32'd0);
      start_pulse();
      wait_done(1'b0, cyc);
      chk32("busy_cycles3", cyc, 32'd50);
      check_vec("two");

      // Partial last chunk: NODES=5, LANES=2
      chk32("small_rst_zero", {31'd0, s_output_fc == '0}, 32'd1);
      @(negedge clk);
      s_input_fc = {SN{16'h3C00}};
      s_start    = 1'b1;
      @(negedge clk);
      s_start    = 1'b0;
      cyc        = 0;
      for (int k = 0; k < 20 && !s_done; k++) begin
         if (s_busy) cyc++;
         @(negedge clk);
      end
      chk32("small_done", {31'd0, s_done}, 32'd1);
      chk32("small_busy_cycles", cyc, 32'd3);
      chk32("small_elem4", s_output_fc[4*32 +: 32], 32'h3F800000);
      chk32("small_all", {31'd0, s_output_fc == {SN{32'h3F800000}}}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fc_convert_scheduler.md
Name: fc_convert_scheduler

Overview:
- Sequenced, area-reduced replacement for the one-shot wide half-to-single converter feeding the FC layers.
- Latches a packed NODES x FP16 vector on a start pulse and converts LANES elements per clock into a packed NODES x FP32 output register.
- Signals completion with a held done/ack handshake.
- Sits between the FP16 conv/pool output stage and the FP32 fully-connected layer.

Parameters:
- DATA_WIDTH_1, 16, input element width (IEEE half: 1 sign, 5 exponent, 10 mantissa).
- DATA_WIDTH_2, 32, output element width (IEEE single).
- NODES, 400, number of elements per vector.
- LANES, 8, elements converted per clock; 1 <= LANES <= NODES.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request conversion of input_fc; sampled in IDLE or DONE.
- input_fc  input  DATA_WIDTH_1*NODES  packed FP16 vector; element i is at [16i+15:16i].
- ack  input  1  downstream consumed output_fc; sampled in DONE only.
- output_fc  output  DATA_WIDTH_2*NODES  packed FP32 result register; element i is at [32i+31:32i].
- busy  output  1  high in RUN.
- done  output  1  high in DONE; output_fc is complete and stable.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; output_fc=0; capture buffer=0; index=0; busy=0; done=0. Reset during RUN or DONE aborts with no partial-completion indication.
- States: IDLE, RUN, DONE. Let C = ceil(NODES/LANES).
- IDLE: if start=1, capture input_fc into the internal buffer, set index=0, go to RUN. Otherwise hold.
- RUN:
  - Each edge converts buffer elements index..min(index+LANES, NODES)-1 and writes them into output_fc. All other elements hold their value.
  - Index advances by LANES each edge.
  - On the edge that writes the final chunk, go to DONE.
  - start and ack are ignored in RUN.
  - input_fc may change freely after capture.
- DONE: done=1 and output_fc holds.
  - ack=1 and start=0: go to IDLE.
  - ack=1 and start=1: capture the new input_fc, index=0, go to RUN. Done deasserts; there is no IDLE bubble.
  - start=1 and ack=0: ignored.
- Timing: with start sampled at edge t, chunks are written at edges t+1..t+C, and done is high from edge t+C. For NODES=400, LANES=8: C=50.
- Partial last chunk (NODES mod LANES != 0): lanes beyond NODES-1 write nothing. Index never addresses beyond NODES-1.
- output_fc is not cleared on start. Every element is overwritten during RUN before done is asserted.
- Per-element conversion, with s = bit15, e = bits14:10, m = bits9:0:
  - e=0, m=0: signed zero, s followed by 31 zeros.
  - e=0, m!=0 (subnormal): flush to signed zero.
  - e=31: s, exponent 0xFF, mantissa {m, 13'b0}. This gives Inf for m=0 and a payload-preserving NaN for m!=0.
  - Otherwise: s, exponent e+112 (8-bit, cannot overflow), mantissa {m, 13'b0}.
- busy and done are registered, mutually exclusive, and both low in IDLE.

Test Plan:
- Reset then idle, NODES=400, LANES=8: output_fc=0, busy=0, done=0; start=0 for 10 cycles -> no state change.
- Elements [0x3C00, 0xC000, 0x7C00, 0x7E00, 0x0000, 0x8000, 0x0001, 0x7BFF], rest 0x3C00, start pulse -> busy high for exactly 50 cycles, then done. Elements 0-7 must read 0x3F800000, 0xC0000000, 0x7F800000, 0x7FC00000, 0x00000000, 0x80000000, 0x00000000, 0x477FE000; all others 0x3F800000.
- NODES=5, LANES=2, input 0x3C00 x5 -> done 3 cycles after start; element 4 = 0x3F800000 after the final edge; no write beyond element 4.
- In DONE, hold ack=0 for 20 cycles with start pulses and input_fc changes -> output_fc and done unchanged. Then ack=1, start=1 in the same cycle -> next edge busy=1, done=0, new vector converted.
- Mid-RUN after 20 chunks: drive reset low asynchronously between edges -> outputs clear immediately, IDLE. Next start produces a correct full result.
- Change input_fc every cycle during RUN -> result matches the vector captured at start.
